// File: rtl/instr_mem_responder.sv
// instr_mem_responder: memory-side responder for the I-cache refill path.
// Returns a 10-beat x 32-bit block a programmable latency after a request.
//
// Ports:
//   clk, arst_n         clock, async active-low reset
//   i_mem_req_addr      requested block address (low bits select the block)
//   i_mem_req_valid     single-cycle request strobe
//   i_mem_ready         controller ready; sampled only before the burst
//   i_wr_en/addr/data   storage write port (word address = block*10+beat)
//   o_mem_data          beat data, zero when not valid
//   o_mem_data_valid    beat strobe
//   o_busy              high while a request is in flight
//   o_req_dropped       sticky flag: a request arrived while busy
module instr_mem_responder #(
    parameter int ADDR_WIDTH      = 8,
    parameter int MEM_DATA_WIDTH  = 32,
    parameter int BEATS_PER_BLOCK = 10,
    parameter int DEPTH_BLOCKS    = 16,
    parameter int LATENCY         = 4,
    parameter int WADDR_WIDTH     = 8
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic [ADDR_WIDTH-1:0]     i_mem_req_addr,
    input  logic                      i_mem_req_valid,
    input  logic                      i_mem_ready,
    input  logic                      i_wr_en,
    input  logic [WADDR_WIDTH-1:0]    i_wr_addr,
    input  logic [MEM_DATA_WIDTH-1:0] i_wr_data,
    output logic [MEM_DATA_WIDTH-1:0] o_mem_data,
    output logic                      o_mem_data_valid,
    output logic                      o_busy,
    output logic                      o_req_dropped
);

    localparam int BLK_W  = $clog2(DEPTH_BLOCKS);
    localparam int CNT_W  = $clog2(BEATS_PER_BLOCK) + 1;
    localparam int NWORDS = DEPTH_BLOCKS * BEATS_PER_BLOCK;

    localparam logic [3:0]         LAT_LOAD = 4'(LATENCY);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(BEATS_PER_BLOCK);
    localparam logic [WADDR_WIDTH:0] WLIMIT = (WADDR_WIDTH+1)'(NWORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BURST
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nx;
    logic [BLK_W-1:0]          r_blk;
    logic [BLK_W-1:0]          w_blk_nx;
    logic [3:0]                r_lat;
    logic [3:0]                w_lat_nx;
    logic [CNT_W-1:0]          r_beat;
    logic [CNT_W-1:0]          w_beat_nx;
    logic                      r_valid;
    logic                      w_valid_nx;
    logic                      r_drop;
    logic                      w_drop_nx;
    logic                      w_load;
    logic [CNT_W-1:0]          w_rd_beat;
    logic [WADDR_WIDTH-1:0]    w_rd_addr;
    logic [WADDR_WIDTH-1:0]    w_blk_ext;
    logic [MEM_DATA_WIDTH-1:0] r_data;
    logic [MEM_DATA_WIDTH-1:0] r_mem [NWORDS];

    // Upper request-address bits are deliberately ignored (address wraps).
    logic w_unused_addr;
    assign w_unused_addr = &{1'b0, i_mem_req_addr[ADDR_WIDTH-1:BLK_W]};

    // block*10 + beat without a multiplier
    assign w_blk_ext = WADDR_WIDTH'(r_blk);
    assign w_rd_addr = (w_blk_ext << 3) + (w_blk_ext << 1)
                     + WADDR_WIDTH'(w_rd_beat);

    always_comb begin
        w_state_nx = r_state;
        w_blk_nx   = r_blk;
        w_lat_nx   = r_lat;
        w_beat_nx  = r_beat;
        w_valid_nx = r_valid;
        w_drop_nx  = r_drop | (i_mem_req_valid && (r_state != S_IDLE));
        w_load     = 1'b0;
        w_rd_beat  = '0;
        unique case (r_state)
            S_IDLE: begin
                if (i_mem_req_valid) begin
                    w_blk_nx   = i_mem_req_addr[BLK_W-1:0];
                    // Counting LATENCY..1 makes the hand-off edge at
                    // lat==1 land beat 0 exactly LATENCY edges later.
                    w_lat_nx   = LAT_LOAD;
                    w_state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_lat > 4'd1) begin
                    w_lat_nx = r_lat - 4'd1;
                end else if (i_mem_ready) begin
                    w_state_nx = S_BURST;
                    w_load     = 1'b1;
                    w_beat_nx  = CNT_W'(1);
                    w_valid_nx = 1'b1;
                end
            end
            S_BURST: begin
                if (r_beat == LAST_CNT) begin
                    w_state_nx = S_IDLE;
                    w_valid_nx = 1'b0;
                    w_beat_nx  = '0;
                end else begin
                    w_load    = 1'b1;
                    w_rd_beat = r_beat;
                    w_beat_nx = r_beat + CNT_W'(1);
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= S_IDLE;
            r_blk   <= '0;
            r_lat   <= '0;
            r_beat  <= '0;
            r_valid <= 1'b0;
            r_drop  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_blk   <= w_blk_nx;
            r_lat   <= w_lat_nx;
            r_beat  <= w_beat_nx;
            r_valid <= w_valid_nx;
            r_drop  <= w_drop_nx;
            r_data  <= w_load ? r_mem[w_rd_addr] : '0;
        end
    end

    // Storage is not reset; same-edge read sees the old word.
    always_ff @(posedge clk) begin
        if (i_wr_en && ({1'b0, i_wr_addr} < WLIMIT)) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_mem_data       = r_data;
    assign o_mem_data_valid = r_valid;
    assign o_busy           = (r_state != S_IDLE);
    assign o_req_dropped    = r_drop;

endmodule

// File: tb/tb_instr_mem_responder.sv
// tb_instr_mem_responder: directed + random refill traffic checked against
// an edge-timing reference model of the responder.
module tb_instr_mem_responder;

    localparam int LAT = 4;
    localparam int NB  = 10;
    localparam int NW  = 160;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic [7:0]  addr = '0;
    logic        req = 1'b0;
    logic        rdy = 1'b0;
    logic        wen = 1'b0;
    logic [7:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] o_mem_data;
    logic        o_mem_data_valid;
    logic        o_busy;
    logic        o_req_dropped;

    always #5 clk = ~clk;

    instr_mem_responder dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .i_mem_req_addr   (addr),
        .i_mem_req_valid  (req),
        .i_mem_ready      (rdy),
        .i_wr_en          (wen),
        .i_wr_addr        (waddr),
        .i_wr_data        (wdata),
        .o_mem_data       (o_mem_data),
        .o_mem_data_valid (o_mem_data_valid),
        .o_busy           (o_busy),
        .o_req_dropped    (o_req_dropped)
    );

    int n_chk = 0;
    int n_pass = 0;
    string phase = "reset";

    logic [31:0] mem_m [NW];
    bit          m_busy = 0;
    bit          m_vld = 0;
    bit          m_drop = 0;
    logic [31:0] m_data = '0;
    int          m_edge = 0;
    int          m_acc = 0;
    int          m_first = -1;
    int          m_blk = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s.%s: got %h want %h", phase, tag, got, exp);
    endtask

    // Burst timing: accepted at edge A, beat 0 at the first edge >= A+LAT
    // with ready high, beats on consecutive edges, idle one edge later.
    task automatic model_edge();
        int k;
        m_edge++;
        if (!m_busy) begin
            if (req) begin
                m_busy  = 1;
                m_acc   = m_edge;
                m_first = -1;
                m_blk   = int'(addr) % 16;
            end
        end else begin
            if (req) m_drop = 1;
            if (m_first < 0 && m_edge >= m_acc + LAT && rdy)
                m_first = m_edge;
            if (m_first >= 0) begin
                k = m_edge - m_first;
                if (k < NB) begin
                    m_vld  = 1;
                    m_data = mem_m[m_blk * NB + k];
                end else begin
                    m_vld  = 0;
                    m_data = '0;
                    m_busy = 0;
                end
            end
        end
        if (wen && int'(waddr) < NW) mem_m[waddr] = wdata;
    endtask

    task automatic check_outs();
        check("data", o_mem_data, m_data);
        check("valid", 32'(o_mem_data_valid), 32'(m_vld));
        check("busy", 32'(o_busy), 32'(m_busy));
        check("drop", 32'(o_req_dropped), 32'(m_drop));
    endtask

    task automatic step(input bit r, input logic [7:0] a, input bit rd,
                        input bit we, input logic [7:0] wa,
                        input logic [31:0] wd);
        @(negedge clk);
        req = r; addr = a; rdy = rd;
        wen = we; waddr = wa; wdata = wd;
        @(posedge clk);
        model_edge();
        #1;
        check_outs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h0, 1, 0, 8'h0, 32'h0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && m_busy; i++) idle(1);
        check("drain_idle", 32'(o_busy), 32'h0);
    endtask

    initial begin
        #1;
        check_outs();
        #20;
        @(negedge clk);
        arst_n = 1'b1;

        phase = "preload";
        for (int w = 0; w < NW; w++)
            step(0, 8'h0, 1, 1, 8'(w), {8'(w / NB), 24'(w % NB)});

        phase = "basic";
        step(1, 8'h03, 1, 0, 8'h0, 32'h0);
        idle(16);

        phase = "stall";
        step(1, 8'h01, 0, 0, 8'h0, 32'h0);
        for (int i = 0; i < 6; i++) step(0, 8'h0, 0, 0, 8'h0, 32'h0);
        step(0, 8'h0, 1, 0, 8'h0, 32'h0);
        for (int i = 0; i < 12; i++)
            step(0, 8'h0, 1'($urandom), 0, 8'h0, 32'h0);
        drain();

        phase = "wrap";
        step(1, 8'h13, 1, 0, 8'h0, 32'h0);
        idle(16);

        phase = "dropped";
        step(1, 8'h03, 1, 0, 8'h0, 32'h0);
        idle(5);
        step(1, 8'h05, 1, 0, 8'h0, 32'h0);
        for (int i = 0; i < 40 && m_busy; i++) idle(1);
        step(1, 8'h07, 1, 0, 8'h0, 32'h0);
        idle(16);

        phase = "wr_burst";
        step(1, 8'h03, 1, 0, 8'h0, 32'h0);
        idle(4);
        step(0, 8'h0, 1, 1, 8'd37, 32'hDEADBEEF);
        idle(1);
        step(0, 8'h0, 1, 1, 8'd33, 32'hCAFE0033);
        idle(12);
        drain();

        phase = "rst_mid";
        step(1, 8'h02, 1, 0, 8'h0, 32'h0);
        idle(8);
        @(negedge clk);
        #2 arst_n = 1'b0;
        #1;
        m_busy = 0; m_vld = 0; m_data = '0; m_drop = 0;
        check_outs();
        @(negedge clk);
        arst_n = 1'b1;
        idle(3);
        step(1, 8'h04, 1, 0, 8'h0, 32'h0);
        idle(16);

        phase = "random";
        for (int i = 0; i < 3000; i++)
            step(($urandom % 8) == 0, 8'($urandom),
                 ($urandom % 10) < 7, ($urandom % 5) == 0,
                 8'($urandom), $urandom);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
